// File: rtl/dmem_dual_port_arbiter.sv
// Serializes up to two per-bundle data memory requests onto the single dmem port.
// A dual bundle stalls the core for one cycle while slot 2 replays from hold registers.
module dmem_dual_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_1,
  input  logic                  req_2,
  input  logic                  wren_1,
  input  logic                  wren_2,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  input  logic [DATA_WIDTH-1:0] wdata_2,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic [DATA_WIDTH-1:0] rdata_2,
  output logic                  rvalid_1,
  output logic                  rvalid_2,
  output logic [CNT_WIDTH-1:0]  conflict_count,
  output logic [ADDR_WIDTH-1:0] address_dmem,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  wren,
  input  logic [DATA_WIDTH-1:0] q_dmem
);

  // state  | meaning
  // IDLE   | accepting bundles; drives slot 1, else slot 2, else nothing
  // SECOND | replaying held slot-2 access; slot inputs ignored
  typedef enum logic {IDLE, SECOND} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic                  hold_wren;
  logic                  capture;
  logic                  load_1;
  logic                  load_2;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      hold_addr      <= '0;
      hold_wdata     <= '0;
      hold_wren      <= 1'b0;
      rdata_1        <= '0;
      rdata_2        <= '0;
      rvalid_1       <= 1'b0;
      rvalid_2       <= 1'b0;
      conflict_count <= '0;
    end else begin
      state    <= state_next;
      rvalid_1 <= load_1;
      rvalid_2 <= load_2;
      if (load_1) rdata_1 <= q_dmem;
      if (load_2) rdata_2 <= q_dmem;
      if (capture) begin
        hold_addr  <= addr_2;
        hold_wdata <= wdata_2;
        hold_wren  <= wren_2;
        if (conflict_count != {CNT_WIDTH{1'b1}})
          conflict_count <= conflict_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_next   = state;
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    stall        = 1'b0;
    capture      = 1'b0;
    load_1       = 1'b0;
    load_2       = 1'b0;
    case (state)
      IDLE: begin
        if (req_1) begin
          address_dmem = addr_1;
          data         = wdata_1;
          wren         = wren_1;
          load_1       = !wren_1;
          if (req_2) begin
            stall      = 1'b1;
            capture    = 1'b1;
            state_next = SECOND;
          end
        end else if (req_2) begin
          address_dmem = addr_2;
          data         = wdata_2;
          wren         = wren_2;
          load_2       = !wren_2;
        end
      end
      SECOND: begin
        address_dmem = hold_addr;
        data         = hold_wdata;
        wren         = hold_wren;
        load_2       = !hold_wren;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset must never let a store through, even from a held slot-2 access.
    if (reset) begin
      wren  = 1'b0;
      stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_dual_port_arbiter.sv
// Bench for dmem_dual_port_arbiter: directed scenarios plus randomized bundles
// checked against a program-order memory model.
module tb_dmem_dual_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_1 = 1'b0, req_2 = 1'b0, wren_1 = 1'b0, wren_2 = 1'b0;
  logic [AW-1:0] addr_1 = '0, addr_2 = '0;
  logic [DW-1:0] wdata_1 = '0, wdata_2 = '0;
  logic          stall, rvalid_1, rvalid_2, wren;
  logic [DW-1:0] rdata_1, rdata_2, data;
  logic [CW-1:0] conflict_count;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] q_dmem = '0;

  logic [DW-1:0] mem [0:4095] = '{default: '0};

  dmem_dual_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .req_1(req_1), .req_2(req_2), .wren_1(wren_1), .wren_2(wren_2),
    .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
    .stall(stall), .rdata_1(rdata_1), .rdata_2(rdata_2),
    .rvalid_1(rvalid_1), .rvalid_2(rvalid_2), .conflict_count(conflict_count),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  // Memory on the inverted clock: samples at the falling edge, read data ready before the rising edge.
  always @(negedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: accesses applied in program order to ref_mem, load results scheduled by cycle.
  logic [DW-1:0] ref_mem [0:4095] = '{default: '0};
  int            p1_at = -1, p2_at = -1;
  logic [DW-1:0] p1_val = '0, p2_val = '0, e_rd1 = '0, e_rd2 = '0;
  bit            m_second = 1'b0;
  logic [AW-1:0] h_a = '0;
  logic [DW-1:0] h_d = '0;
  logic          h_w = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  bit            regs_known = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cyc_step(input logic rst,
                          input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic r2, input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    logic          ev1, ev2, es, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge clock);
    #1;
    reset = rst; req_1 = r1; wren_1 = w1; addr_1 = a1; wdata_1 = d1;
    req_2 = r2; wren_2 = w2; addr_2 = a2; wdata_2 = d2;
    #1;
    cyc++;
    if (regs_known) begin
      ev1 = (p1_at == cyc);
      ev2 = (p2_at == cyc);
      if (ev1) e_rd1 = p1_val;
      if (ev2) e_rd2 = p2_val;
      chk("rvalid_1", rvalid_1, ev1);
      chk("rdata_1", rdata_1, e_rd1);
      chk("rvalid_2", rvalid_2, ev2);
      chk("rdata_2", rdata_2, e_rd2);
      chk("conflict_count", conflict_count, m_cnt);
    end
    es = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    if (m_second) begin
      ea = h_a; ed = h_d; ew = h_w;
      if (!rst) begin
        if (h_w) ref_mem[h_a] = h_d;
        else begin p2_at = cyc + 1; p2_val = ref_mem[h_a]; end
      end
      m_second = 1'b0;
    end else if (r1) begin
      ea = a1; ed = d1; ew = w1;
      if (!rst) begin
        if (w1) ref_mem[a1] = d1;
        else begin p1_at = cyc + 1; p1_val = ref_mem[a1]; end
        if (r2) begin
          es = 1'b1; m_second = 1'b1; h_a = a2; h_d = d2; h_w = w2;
          if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
      end
    end else if (r2) begin
      ea = a2; ed = d2; ew = w2;
      if (!rst) begin
        if (w2) ref_mem[a2] = d2;
        else begin p2_at = cyc + 1; p2_val = ref_mem[a2]; end
      end
    end
    chk("stall", stall, es);
    chk("wren", wren, rst ? 1'b0 : ew);
    if (!rst) begin
      chk("address_dmem", address_dmem, ea);
      chk("data", data, ed);
    end
    if (rst) begin
      e_rd1 = '0; e_rd2 = '0; p1_at = -1; p2_at = -1;
      m_second = 1'b0; m_cnt = '0; regs_known = 1'b1;
    end
  endtask

  task automatic idle();
    cyc_step(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  logic [CW-1:0] sat_exp [0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    logic          rr, r1, r2, w1, w2;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d1, d2;

    cyc_step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    cyc_step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    chk("reset_stall", stall, 1'b0);

    // Single load
    cyc_step(0, 1, 1, 12'd5, 32'hDEADBEEF, 0, 0, '0, '0);
    cyc_step(0, 1, 0, 12'd5, '0, 0, 0, '0, '0);
    chk("single_addr", address_dmem, 12'd5);
    idle();
    chk("single_rdata", rdata_1, 32'hDEADBEEF);
    chk("single_rvalid_2", rvalid_2, 1'b0);

    // Dual load
    cyc_step(0, 1, 1, 12'd3, 32'h11, 0, 0, '0, '0);
    cyc_step(0, 0, 0, '0, '0, 1, 1, 12'd9, 32'h22);
    cyc_step(0, 1, 0, 12'd3, '0, 1, 0, 12'd9, '0);
    chk("dual_stall", stall, 1'b1);
    cyc_step(0, 1, 0, 12'd3, '0, 1, 0, 12'd9, '0);
    chk("dual_addr2", address_dmem, 12'd9);
    chk("dual_rdata_1", rdata_1, 32'h11);
    idle();
    chk("dual_rdata_2", rdata_2, 32'h22);
    chk("dual_rvalid_2", rvalid_2, 1'b1);
    chk("dual_count", conflict_count, 2'd1);

    // Store then load in one bundle
    cyc_step(0, 1, 1, 12'd7, 32'hCAFE, 1, 0, 12'd7, '0);
    cyc_step(0, 1, 1, 12'd7, 32'hCAFE, 1, 0, 12'd7, '0);
    chk("stld_wren_c1", wren, 1'b0);
    idle();
    chk("stld_rdata_2", rdata_2, 32'hCAFE);

    // Dual store to the same address
    cyc_step(0, 1, 1, 12'd4, 32'hAAAA, 1, 1, 12'd4, 32'hBBBB);
    cyc_step(0, 1, 1, 12'd4, 32'hAAAA, 1, 1, 12'd4, 32'hBBBB);
    chk("dst_wren_c1", wren, 1'b1);
    cyc_step(0, 1, 0, 12'd4, '0, 0, 0, '0, '0);
    idle();
    chk("dst_rdata", rdata_1, 32'hBBBB);

    // Reset while replaying slot 2
    cyc_step(0, 1, 0, 12'd2, '0, 1, 1, 12'd8, 32'h55);
    cyc_step(1, 1, 0, 12'd2, '0, 1, 1, 12'd8, 32'h55);
    idle();
    chk("rst2_count", conflict_count, 2'd0);
    chk("rst2_rdata_1", rdata_1, 32'h0);
    chk("rst2_rvalid_2", rvalid_2, 1'b0);
    idle();
    chk("rst2_mem8", mem[8], 32'h0);

    // Counter saturation
    for (int i = 0; i < 5; i++) begin
      cyc_step(0, 1, 0, 12'd3, '0, 1, 0, 12'd9, '0);
      cyc_step(0, 1, 0, 12'd3, '0, 1, 0, 12'd9, '0);
      chk("sat_count", conflict_count, sat_exp[i]);
    end

    // Randomized bundles; a dual bundle is followed by a cycle of unrelated inputs
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 39) == 0);
      r1 = 1'($urandom_range(0, 1)); r2 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1)); w2 = 1'($urandom_range(0, 1));
      a1 = AW'($urandom_range(0, 15)); a2 = AW'($urandom_range(0, 15));
      d1 = $urandom; d2 = $urandom;
      cyc_step(rr, r1, w1, a1, d1, r2, w2, a2, d2);
      if (r1 && r2 && !rr) begin
        rr = ($urandom_range(0, 7) == 0);
        cyc_step(rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), $urandom);
      end
    end
    idle();
    idle();
    for (int a = 0; a < 16; a++) chk("mem_final", mem[a], ref_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
